// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic arbiter: round-robin grant held for a whole CYC,
// with a per-transfer ACK timeout that aborts the owner and frees the slave.
module wb_arbiter_2m #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, TERR} state_t;

  localparam int             TCW   = $clog2(TIMEOUT + 1);
  localparam logic [TCW-1:0] TLAST = TCW'(TIMEOUT - 1);

  state_t         state, state_d;
  logic           last, last_d;
  logic           errm, errm_d;
  logic [TCW-1:0] tcnt, tcnt_d;
  logic           req0, req1;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      tcnt  <= '0;
      errm  <= 1'b0;
    end else begin
      state <= state_d;
      last  <= last_d;
      tcnt  <= tcnt_d;
      errm  <= errm_d;
    end
  end

  // tcnt only survives a cycle while the owner is strobing without an ACK
  always_comb begin
    state_d = state;
    last_d  = last;
    errm_d  = errm;
    tcnt_d  = '0;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          if (req1) begin
            state_d = GNT1;
            last_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (m0_stb_i && !s_ack_i) begin
          if (tcnt == TLAST) begin
            state_d = TERR;
            errm_d  = 1'b0;
          end else begin
            tcnt_d = tcnt + TCW'(1);
          end
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          if (req0) begin
            state_d = GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (m1_stb_i && !s_ack_i) begin
          if (tcnt == TLAST) begin
            state_d = TERR;
            errm_d  = 1'b1;
          end else begin
            tcnt_d = tcnt + TCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    gnt_o    = 2'b00;
    case (state)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
        gnt_o    = 2'b01;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
        gnt_o    = 2'b10;
      end
      TERR: begin
        m0_err_o = ~errm;
        m1_err_o = errm;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed scenarios plus randomized traffic, every
// cycle compared against a transaction-level model of ownership and timeouts.
module tb_wb_arbiter_2m;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          mcyc[2];
  logic          mstb[2];
  logic          mwe[2];
  logic [AW-1:0] madr[2];
  logic [DW-1:0] mdi[2];
  logic [DW-1:0] mdo[2];
  logic          mack[2];
  logic          merr[2];
  logic          s_cyc, s_stb, s_we, s_ack;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_o, s_dat_i;
  logic [1:0]    gnt;

  int checks = 0;
  int errors = 0;

  // model: which master owns the slave (-1 none), pending abort, rr history
  int own   = -1;
  int errm  = -1;
  int last  = 1;
  int waitc = 0;

  logic       obs_scyc, obs_swe;
  logic [DW-1:0] obs_sdat;
  logic [1:0] obs_gnt;
  logic       obs_ack[2];
  logic       obs_err[2];

  always #5 clk = ~clk;

  wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]),
    .m0_adr_i(madr[0]), .m0_dat_i(mdi[0]), .m0_dat_o(mdo[0]),
    .m0_ack_o(mack[0]), .m0_err_o(merr[0]),
    .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]),
    .m1_adr_i(madr[1]), .m1_dat_i(mdi[1]), .m1_dat_o(mdo[1]),
    .m1_ack_o(mack[1]), .m1_err_o(merr[1]),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack),
    .gnt_o(gnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input int m, input logic c, input logic s, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    mcyc[m] = c;
    mstb[m] = s;
    mwe[m]  = w;
    madr[m] = a;
    mdi[m]  = d;
  endtask

  // Called 1ns after a rising edge: compare at the falling edge, advance the
  // model on the next rising edge, return 1ns after it.
  task automatic step();
    logic [2:0]    e_sctl;
    logic [AW-1:0] e_sadr;
    logic [DW-1:0] e_sdat;
    logic [1:0]    e_gnt;
    logic          e_ack[2];
    logic          e_err[2];
    logic [DW-1:0] e_mdat[2];
    logic          req[2];
    int            nown;
    #4;
    e_sctl = '0; e_sadr = '0; e_sdat = '0; e_gnt = '0;
    for (int m = 0; m < 2; m++) begin
      e_ack[m] = 1'b0; e_err[m] = 1'b0; e_mdat[m] = '0;
    end
    if (own >= 0) begin
      e_sctl       = {mcyc[own], mstb[own], mwe[own]};
      e_sadr       = madr[own];
      e_sdat       = mdi[own];
      e_ack[own]   = s_ack;
      e_mdat[own]  = s_dat_i;
      e_gnt        = 2'(1 << own);
    end
    if (errm >= 0) e_err[errm] = 1'b1;
    check("s_ctl", 64'({s_cyc, s_stb, s_we}), 64'(e_sctl));
    check("s_adr", 64'(s_adr), 64'(e_sadr));
    check("s_dat", 64'(s_dat_o), 64'(e_sdat));
    check("gnt", 64'(gnt), 64'(e_gnt));
    check("ack0", 64'(mack[0]), 64'(e_ack[0]));
    check("ack1", 64'(mack[1]), 64'(e_ack[1]));
    check("err0", 64'(merr[0]), 64'(e_err[0]));
    check("err1", 64'(merr[1]), 64'(e_err[1]));
    check("dat0", 64'(mdo[0]), 64'(e_mdat[0]));
    check("dat1", 64'(mdo[1]), 64'(e_mdat[1]));
    obs_scyc = s_cyc; obs_swe = s_we; obs_sdat = s_dat_o; obs_gnt = gnt;
    for (int m = 0; m < 2; m++) begin
      obs_ack[m] = mack[m]; obs_err[m] = merr[m];
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) req[m] = mcyc[m] & mstb[m];
    if (!rst) begin
      own = -1; errm = -1; last = 1; waitc = 0;
    end else if (errm >= 0) begin
      errm = -1; waitc = 0;
    end else if (own < 0) begin
      if (req[0] && req[1]) own = 1 - last;
      else if (req[0]) own = 0;
      else if (req[1]) own = 1;
      if (own >= 0) last = own;
      waitc = 0;
    end else if (!mcyc[own]) begin
      nown = 1 - own;
      if (req[nown]) begin
        own = nown; last = nown;
      end else begin
        own = -1;
      end
      waitc = 0;
    end else if (mstb[own] && !s_ack) begin
      if (waitc == TIMEOUT - 1) begin
        errm = own; own = -1; waitc = 0;
      end else begin
        waitc++;
      end
    end else begin
      waitc = 0;
    end
    #1;
  endtask

  initial begin
    int erri;
    int errseen;
    int ack_pct;
    logic scyc_seq[12];
    logic [1:0] gnt_seq[12];

    rst = 1'b0; s_ack = 1'b0; s_dat_i = '0;
    for (int m = 0; m < 2; m++) drive(m, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;

    // reset held with both masters requesting
    drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h1);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h2);
    s_dat_i = 32'hDEAD_BEEF;
    repeat (3) begin
      step();
      check("rst_gnt", 64'(obs_gnt), 64'(2'b00));
      check("rst_scyc", 64'(obs_scyc), 64'(1'b0));
    end
    rst = 1'b1;
    step();
    step();
    check("rst_rel_gnt", 64'(obs_gnt), 64'(2'b01));
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(); step();

    // single write by m0, ACK after four wait cycles
    drive(0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0003_0201);
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("wr_sdat", 64'(obs_sdat), 64'(32'h0003_0201));
      check("wr_swe", 64'(obs_swe), 64'(1'b1));
      check("wr_wait_ack", 64'(obs_ack[0]), 64'(1'b0));
    end
    s_ack = 1'b1;
    step();
    check("wr_ack0", 64'(obs_ack[0]), 64'(1'b1));
    check("wr_ack1", 64'(obs_ack[1]), 64'(1'b0));
    s_ack = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(); step();
    check("wr_idle", 64'(obs_gnt), 64'(2'b00));

    // continuous tie with single-cycle transfers: m0 was served last
    s_ack = 1'b1;
    drive(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'hA0);
    drive(1, 1'b1, 1'b1, 1'b1, 32'h200, 32'hB0);
    for (int i = 0; i < 12; i++) begin
      step();
      scyc_seq[i] = obs_scyc;
      gnt_seq[i]  = obs_gnt;
      for (int m = 0; m < 2; m++) begin
        if (obs_ack[m] && mcyc[m]) begin
          mcyc[m] = 1'b0; mstb[m] = 1'b0;
        end else begin
          mcyc[m] = 1'b1; mstb[m] = 1'b1;
        end
      end
    end
    for (int i = 1; i < 12; i++) begin
      check("rr_scyc", 64'(scyc_seq[i]), 64'(i % 2));
      if (i % 2 == 1)
        check("rr_gnt", 64'(gnt_seq[i]), 64'(((i / 2) % 2 == 0) ? 2'b10 : 2'b01));
    end
    s_ack = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(); step(); step();

    // hand-over: m1 waits for m0's CYC to end, then takes over without IDLE
    drive(0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h4444);
    step(); step(); step();
    drive(1, 1'b1, 1'b1, 1'b1, 32'h88, 32'h8888);
    step();
    check("ho_hold", 64'(obs_gnt), 64'(2'b01));
    step();
    check("ho_hold", 64'(obs_gnt), 64'(2'b01));
    s_ack = 1'b1;
    step();
    check("ho_ack0", 64'(obs_ack[0]), 64'(1'b1));
    s_ack = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    step();
    check("ho_gap_scyc", 64'(obs_scyc), 64'(1'b0));
    check("ho_gap_gnt", 64'(obs_gnt), 64'(2'b01));
    step();
    check("ho_gnt", 64'(obs_gnt), 64'(2'b10));
    s_ack = 1'b1;
    step();
    check("ho_ack1", 64'(obs_ack[1]), 64'(1'b1));
    s_ack = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(); step();

    // timeout on m1; m0 queues up meanwhile and is served next
    drive(1, 1'b1, 1'b1, 1'b0, 32'h99, 32'h9);
    step();
    erri = -1;
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      step();
      if (i == 2) drive(0, 1'b1, 1'b1, 1'b0, 32'h55, 32'h5);
      if (obs_err[1] && erri < 0) begin
        erri = i;
        check("to_scyc", 64'(obs_scyc), 64'(1'b0));
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
      end
    end
    check("to_cycle", 64'(erri), 64'(TIMEOUT));
    check("to_next", 64'(obs_gnt), 64'(2'b01));
    s_ack = 1'b1;
    step();
    check("to_ack0", 64'(obs_ack[0]), 64'(1'b1));
    s_ack = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(); step();

    // ACK in the last allowed wait cycle is a normal completion
    drive(1, 1'b1, 1'b1, 1'b1, 32'h77, 32'h7);
    step();
    errseen = 0;
    for (int i = 0; i < TIMEOUT + 3; i++) begin
      s_ack = (i == TIMEOUT - 1);
      step();
      if (obs_err[1] || obs_err[0]) errseen++;
      if (i == TIMEOUT - 1) begin
        check("late_ack1", 64'(obs_ack[1]), 64'(1'b1));
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
      end
    end
    check("late_noerr", 64'(errseen), 64'(0));
    s_ack = 1'b0;
    step();

    // reset in the middle of a GNT1 wait
    drive(1, 1'b1, 1'b1, 1'b0, 32'h66, 32'h6);
    step(); step(); step();
    drive(0, 1'b1, 1'b1, 1'b0, 32'h33, 32'h3);
    step();
    rst = 1'b0;
    step();
    check("rm_scyc_pre", 64'(obs_scyc), 64'(1'b1));
    rst = 1'b1;
    step();
    check("rm_scyc", 64'(obs_scyc), 64'(1'b0));
    check("rm_err", 64'({obs_err[0], obs_err[1]}), 64'(2'b00));
    check("rm_ack", 64'({obs_ack[0], obs_ack[1]}), 64'(2'b00));
    step();
    check("rm_tie", 64'(obs_gnt), 64'(2'b01));
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    step(); step();

    // randomized traffic
    ack_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) begin
        case ($urandom_range(0, 2))
          0: ack_pct = 0;
          1: ack_pct = 25;
          default: ack_pct = 60;
        endcase
      end
      rst     = ($urandom_range(0, 299) != 0);
      s_ack   = ($urandom_range(0, 99) < ack_pct);
      s_dat_i = $urandom;
      step();
      for (int m = 0; m < 2; m++) begin
        if (!mcyc[m]) begin
          if ($urandom_range(0, 2) == 0)
            drive(m, 1'b1, 1'b1, 1'($urandom), $urandom, $urandom);
        end else if ((obs_ack[m] && mstb[m]) || obs_err[m]) begin
          if ($urandom_range(0, 1) == 0)
            drive(m, 1'b0, 1'b0, 1'b0, '0, '0);
          else
            drive(m, 1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom);
        end else if (!mstb[m] && $urandom_range(0, 1) == 0) begin
          mstb[m] = 1'b1;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master, one-slave Wishbone classic arbiter. It lets the bench/CPU master (m0) and the autonomous configuration sequencer (m1) share the serial-output peripheral's register port (CYC/STB/WE/ADR/DAT/ACK). Arbitration is round-robin, and a grant is held for a whole CYC. A per-transfer ACK timeout returns an error and frees the slave if it never acknowledges.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, consecutive unacknowledged STB cycles before abort (≥2)
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous, active-low reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle/strobe/write
- m0_adr_i  in  AW  master 0 address
- m0_dat_i  in  DW  master 0 write data
- m0_dat_o  out  DW  read data to master 0
- m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge / timeout error
- m1_* : identical set for master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_adr_o  out  AW ; s_dat_o  out  DW ; s_dat_i  in  DW ; s_ack_i  in  1
- gnt_o  out  2  one-hot current grant (bit0 = m0), 00 when idle

## Operation
- States: IDLE, GNT0, GNT1, TERR. Registers: state, last (last-served master), tcnt (timeout counter, $clog2(TIMEOUT+1) bits), errm (master being aborted).
- Request: reqX = mX_cyc_i & mX_stb_i.
- IDLE:
  - Only one master requesting → GNTx.
  - Both requesting → grant goes to the master ≠ last.
  - After reset, last = 1, so m0 wins the first tie.
- GNTx:
  - last ← x on entry.
  - Slave outputs are combinationally muxed from master x.
  - mX_ack_o = s_ack_i, mX_dat_o = s_dat_i.
  - The non-granted master sees ack = 0, dat = 0.
- Release: in GNTx with mX_cyc_i = 0:
  - Other master requesting → GNTy (direct hand-over).
  - Otherwise → IDLE.
  - s_cyc_o is low for that cycle because it follows the released master.
- Timeout:
  - In GNTx, tcnt increments each cycle with mX_stb_i = 1 & s_ack_i = 0.
  - tcnt clears on s_ack_i or when stb is low.
  - When tcnt = TIMEOUT-1 and still no ACK → TERR, errm ← x.
- TERR (exactly one cycle):
  - m{errm}_err_o = 1.
  - s_cyc_o = s_stb_o = 0, all acks 0.
  - Next state IDLE, tcnt ← 0.
- Ordinary arbitration resumes from IDLE. A master still holding CYC after err is re-arbitrated like a new request.
- Outputs not owned by the granted master are driven 0: s_* in IDLE/TERR, ack/err/dat to the idle master.

## Timing
- Reset: state IDLE, last = 1, tcnt = 0, errm = 0. Every output is therefore 0: s_*, m*_ack_o, m*_err_o, m*_dat_o, gnt_o.
- Reset is sampled on the clock edge and overrides everything, including mid-transfer. s_cyc_o drops in the cycle after the edge at which rst_i = 0 is sampled.
- Grant latency: request sampled in IDLE at edge N → GNTx from edge N; s_cyc_o/s_stb_o visible in cycle N+1.
- ACK path is combinational: zero added latency from s_ack_i to mX_ack_o.
- Hand-over gap: exactly one cycle of s_cyc_o = 0 between masters.
- Timeout: with STB asserted from cycle k and no ACK, TERR occupies cycle k+TIMEOUT and err is high for that single cycle.
- An ACK arriving in the same cycle as tcnt = TIMEOUT-1 wins: it is a normal ACK, no error.
- s_ack_i asserted while not granted (IDLE/TERR) is ignored.
- gnt_o is registered from state and valid from the cycle after the grant edge.

## Test plan
- Reset: hold rst_i = 0 for 3 cycles with both masters requesting → all outputs 0, gnt_o = 00; release → gnt_o = 01 one cycle later.
- Single write: m0 writes ADR = 0, DAT = 32'h0003_0201, slave ACKs after 4 cycles → s_dat_o = 32'h0003_0201 and s_we_o = 1 throughout, m0_ack_o pulses 1 cycle, m1_ack_o stays 0, IDLE after m0 drops CYC.
- Tie/round-robin: both masters request continuously with 1-cycle transfers, each dropping CYC after ACK → grants alternate m0, m1, m0, m1, one idle s_cyc_o cycle between each.
- Hand-over: m1 requests while m0 mid-transfer → m1 not granted until m0 drops CYC, then gnt_o 01 → 10 directly with no IDLE.
- Timeout: TIMEOUT = 8, m1 strobes and slave never ACKs → m1_err_o high in exactly the 8th cycle after STB, s_cyc_o = 0 that cycle, m0 served next. Repeat with ACK in cycle 8 → no error.
- Reset mid-transfer: assert rst_i = 0 during a GNT1 wait → s_cyc_o drops the cycle after the sampling edge, no err/ack, m0 wins the first post-reset tie.
